// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one iterative shift-add multiplier among NUM_REQ requesters.
// Each granted request runs WIDTH add/shift steps, then holds a tagged result until it is accepted.
module mul_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WIDTH-1:0]       res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [2*WIDTH-1:0] r_b_sh;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last_grant;

  logic               w_found;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_ready;

  // Scan starts one past the last winner, so a held request is served within NUM_REQ grants.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      w_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_id         <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a_sh       <= req_a[int'(w_win)*WIDTH +: WIDTH];
            r_b_sh       <= {{WIDTH{1'b0}}, req_b[int'(w_win)*WIDTH +: WIDTH]};
            r_acc        <= '0;
            r_count      <= '0;
            r_id         <= w_win;
            r_last_grant <= w_win;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          // Fixed WIDTH-step schedule: zero operands still take the full latency.
          if (r_a_sh[0]) begin
            r_acc <= r_acc + r_b_sh;
          end
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh << 1;
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign res_valid = (r_state == S_DONE);
  assign res_data  = r_acc;
  assign res_id    = r_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of grant order and products.
module tb_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;
  localparam int DONE_PH = WIDTH + 1;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     res_valid;
  logic                     res_ready;
  logic [2*WIDTH-1:0]       res_data;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  int          nChecks;
  int          nFails;
  int          mPhase;
  int          mLast;
  int          mId;
  int unsigned mProd;

  mul_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model phase: 0 idle, 1..WIDTH multiply steps, WIDTH+1 result waiting.
  function automatic int expWinner();
    if (!rst_n || mPhase != 0) return -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req_valid[(mLast + k) % NUM_REQ]) return (mLast + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] expReady();
    logic [NUM_REQ-1:0] r;
    int w;
    r = '0;
    w = expWinner();
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic advance();
    int w;
    if (!rst_n) begin
      mPhase = 0;
      mLast  = NUM_REQ - 1;
    end else if (mPhase == 0) begin
      w = expWinner();
      if (w >= 0) begin
        mProd  = int'(req_a[w*WIDTH +: WIDTH]) * int'(req_b[w*WIDTH +: WIDTH]);
        mId    = w;
        mLast  = w;
        mPhase = 1;
      end
    end else if (mPhase <= WIDTH) begin
      mPhase++;
    end else if (res_ready) begin
      mPhase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
  endtask

  task automatic waitResult(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 4*WIDTH) begin
      @(negedge clk);
      n++;
      if (res_valid === 1'b1) ok = 1'b1;
      else advance();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    mPhase    = 0;
    mLast     = NUM_REQ - 1;
    @(negedge clk);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_res_valid: got %0b expected 0", res_valid); end
    nChecks++; if (res_data !== '0) begin nFails++; $display("[TB] FAIL reset_res_data: got %0d expected 0", res_data); end
    nChecks++; if (res_id !== '0) begin nFails++; $display("[TB] FAIL reset_res_id: got %0d expected 0", res_id); end
    nChecks++; if (req_ready !== '0) begin nFails++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
    advance();
    rst_n     = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_op(input int ch, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int expProd);
    bit ok;
    int n;
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[ch] = 1'b1;
    req_a[ch*WIDTH +: WIDTH] = a;
    req_b[ch*WIDTH +: WIDTH] = b;
    req_valid = oh;
    res_ready = 1'b1;
    @(negedge clk);
    nChecks++; if (req_ready !== oh) begin nFails++; $display("[TB] FAIL op_grant ch%0d: got %b expected %b", ch, req_ready, oh); end
    advance();
    req_valid = '0;
    waitResult(ok, n);
    nChecks++; if (!ok || n != WIDTH + 1) begin nFails++; $display("[TB] FAIL op_latency ch%0d: got %0d cycles expected %0d", ch, n, WIDTH + 1); end
    nChecks++; if (res_data !== 16'(expProd)) begin nFails++; $display("[TB] FAIL op_data %0d*%0d: got %0d expected %0d", a, b, res_data, expProd); end
    nChecks++; if (res_id !== ID_W'(ch)) begin nFails++; $display("[TB] FAIL op_id: got %0d expected %0d", res_id, ch); end
    if (ok) advance();
    @(negedge clk);
    nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL op_valid_drop: got %0b expected 0", res_valid); end
    advance();
  endtask

  task automatic test_single_op();
    test_op(0, 8'd13, 8'd11, 143);
  endtask

  task automatic test_extremes();
    test_op(2, 8'd255, 8'd255, 65025);
    test_op(1, 8'd0, 8'd200, 0);
    test_op(3, 8'd1, 8'd255, 255);
  endtask

  task automatic test_round_robin();
    int orderExp[5] = '{0, 1, 2, 3, 0};
    int pend[$];
    logic [WIDTH-1:0] av[NUM_REQ];
    logic [WIDTH-1:0] bv[NUM_REQ];
    logic [NUM_REQ-1:0] exp;
    int grants, results, cyc, e;
    pulseReset();
    for (int ch = 0; ch < NUM_REQ; ch++) begin
      av[ch] = WIDTH'($urandom_range(1, 255));
      bv[ch] = WIDTH'($urandom_range(1, 255));
      req_a[ch*WIDTH +: WIDTH] = av[ch];
      req_b[ch*WIDTH +: WIDTH] = bv[ch];
    end
    req_valid = '1;
    res_ready = 1'b1;
    grants = 0; results = 0; cyc = 0;
    while (results < 5 && cyc < 100) begin
      @(negedge clk);
      if (req_ready !== '0 && grants < 5) begin
        exp = '0;
        exp[orderExp[grants]] = 1'b1;
        nChecks++; if (req_ready !== exp) begin nFails++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", grants, req_ready, exp); end
        pend.push_back(orderExp[grants]);
        grants++;
      end
      if (res_valid === 1'b1 && pend.size() > 0) begin
        e = pend.pop_front();
        nChecks++; if (res_id !== ID_W'(e)) begin nFails++; $display("[TB] FAIL rr_id: got %0d expected %0d", res_id, e); end
        nChecks++; if (res_data !== 16'(int'(av[e]) * int'(bv[e]))) begin nFails++; $display("[TB] FAIL rr_data ch%0d: got %0d expected %0d", e, res_data, int'(av[e]) * int'(bv[e])); end
        results++;
      end
      advance();
      cyc++;
    end
    req_valid = '0;
    nChecks++; if (results != 5) begin nFails++; $display("[TB] FAIL rr_timeout: got %0d results expected 5", results); end
    repeat (WIDTH + 4) advance();
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] a, b;
    int prod, n;
    bit ok;
    a = WIDTH'($urandom_range(0, 255));
    b = WIDTH'($urandom_range(0, 255));
    prod = int'(a) * int'(b);
    req_a[1*WIDTH +: WIDTH] = a;
    req_b[1*WIDTH +: WIDTH] = b;
    req_valid = 4'b0010;
    res_ready = 1'b0;
    @(negedge clk);
    nChecks++; if (req_ready !== 4'b0010) begin nFails++; $display("[TB] FAIL bp_grant: got %b expected 0010", req_ready); end
    advance();
    req_valid = '1;
    waitResult(ok, n);
    nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL bp_timeout: got no result expected one within %0d cycles", 4*WIDTH); end
    if (ok) begin
      for (int i = 0; i < 20; i++) begin
        nChecks++; if (res_valid !== 1'b1 || res_data !== 16'(prod) || res_id !== ID_W'(1)) begin
          nFails++; $display("[TB] FAIL bp_hold%0d: got v=%0b d=%0d id=%0d expected v=1 d=%0d id=1", i, res_valid, res_data, res_id, prod);
        end
        nChecks++; if (req_ready !== '0) begin nFails++; $display("[TB] FAIL bp_no_grant%0d: got %b expected 0000", i, req_ready); end
        advance();
        @(negedge clk);
      end
      advance();
      res_ready = 1'b1;
      @(negedge clk);
      nChecks++; if (res_valid !== 1'b1 || res_data !== 16'(prod)) begin nFails++; $display("[TB] FAIL bp_accept: got v=%0b d=%0d expected v=1 d=%0d", res_valid, res_data, prod); end
      advance();
      @(negedge clk);
      nChecks++; if (res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL bp_drop: got %0b expected 0", res_valid); end
      nChecks++; if (req_ready !== 4'b0100) begin nFails++; $display("[TB] FAIL bp_next_grant: got %b expected 0100", req_ready); end
      advance();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (WIDTH + 4) advance();
  endtask

  task automatic test_reset_midop();
    bit ok;
    int n;
    pulseReset();
    req_a[1*WIDTH +: WIDTH] = 8'd100;
    req_b[1*WIDTH +: WIDTH] = 8'd100;
    req_valid = 4'b0010;
    res_ready = 1'b1;
    @(negedge clk);
    nChecks++; if (req_ready !== 4'b0010) begin nFails++; $display("[TB] FAIL mid_grant: got %b expected 0010", req_ready); end
    advance();
    req_valid = '0;
    advance();
    advance();
    rst_n = 1'b0;
    req_valid = '1;
    @(negedge clk);
    nChecks++; if (req_ready !== '0) begin nFails++; $display("[TB] FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    advance();
    rst_n = 1'b1;
    req_a[0*WIDTH +: WIDTH] = 8'd2;
    req_b[0*WIDTH +: WIDTH] = 8'd3;
    req_a[3*WIDTH +: WIDTH] = 8'd7;
    req_b[3*WIDTH +: WIDTH] = 8'd6;
    req_valid = 4'b1001;
    @(negedge clk);
    nChecks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_abandon: got busy=%0b v=%0b expected 0 0", busy, res_valid); end
    nChecks++; if (req_ready !== 4'b0001) begin nFails++; $display("[TB] FAIL mid_prio0: got %b expected 0001", req_ready); end
    advance();
    req_valid = 4'b1000;
    waitResult(ok, n);
    nChecks++; if (!ok || res_data !== 16'd6 || res_id !== 2'd0) begin nFails++; $display("[TB] FAIL mid_ch0: got ok=%0b d=%0d id=%0d expected 1 6 0", ok, res_data, res_id); end
    if (ok) advance();
    @(negedge clk);
    nChecks++; if (req_ready !== 4'b1000) begin nFails++; $display("[TB] FAIL mid_grant3: got %b expected 1000", req_ready); end
    advance();
    req_valid = '0;
    waitResult(ok, n);
    nChecks++; if (!ok || res_data !== 16'd42 || res_id !== 2'd3) begin nFails++; $display("[TB] FAIL mid_ch3: got ok=%0b d=%0d id=%0d expected 1 42 3", ok, res_data, res_id); end
    if (ok) advance();
    repeat (2) advance();
  endtask

  task automatic test_random();
    int ops, cyc;
    ops = 0;
    cyc = 0;
    while (ops < 1000 && cyc < 60000) begin
      req_valid = NUM_REQ'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      nChecks++; if (req_ready !== expReady()) begin nFails++; $display("[TB] FAIL rnd_ready cyc%0d: got %b expected %b", cyc, req_ready, expReady()); end
      nChecks++; if ($countones(req_ready) > 1) begin nFails++; $display("[TB] FAIL rnd_onehot cyc%0d: got %b expected at most one bit", cyc, req_ready); end
      nChecks++; if (busy !== (mPhase != 0)) begin nFails++; $display("[TB] FAIL rnd_busy cyc%0d: got %0b expected %0b", cyc, busy, mPhase != 0); end
      nChecks++; if (res_valid !== (mPhase == DONE_PH)) begin nFails++; $display("[TB] FAIL rnd_valid cyc%0d: got %0b expected %0b", cyc, res_valid, mPhase == DONE_PH); end
      if (mPhase == DONE_PH) begin
        nChecks++; if (res_data !== 16'(mProd) || res_id !== ID_W'(mId)) begin
          nFails++; $display("[TB] FAIL rnd_result cyc%0d: got d=%0d id=%0d expected d=%0d id=%0d", cyc, res_data, res_id, mProd, mId);
        end
        if (res_ready) ops++;
      end
      advance();
      cyc++;
    end
    nChecks++; if (ops != 1000) begin nFails++; $display("[TB] FAIL rnd_timeout: got %0d ops expected 1000", ops); end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    test_reset();
    test_single_op();
    test_extremes();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one iterative shift-add 8x8 multiply engine among NUM_REQ requesters.
- Each requester uses a valid/ready request channel. Grants are round-robin.
- The block sequences the engine through load, WIDTH add/shift steps, and result hold.
- It returns a single result channel tagged with the winning requester's ID. It sits between client blocks and the multiply datapath.

Parameters:
NUM_REQ, 4, number of requester channels (2..8)
WIDTH, 8, operand width; product is 2*WIDTH bits
ID_W, $clog2(NUM_REQ), width of requester ID (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ*WIDTH  multiplicand per requester, slice i = [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  multiplier per requester, same slicing
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  2*WIDTH  product a*b
res_id  output  ID_W  index of requester that issued this result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - rst_n low at a rising edge sets state=IDLE, res_valid=0, res_data=0, res_id=0, busy=0, all req_ready=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the operation. No result is produced and no req_ready is asserted in that cycle.
- FSM: IDLE -> RUN -> DONE -> IDLE. There are no other states.
- IDLE:
  - req_ready is combinational. Only the winner's bit is high. The winner is the first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - If no request is valid, req_ready=0 and the FSM stays in IDLE.
  - On handshake, the block captures a_sh=req_a[win], b_sh=zero-extended req_b[win] (2*WIDTH bits), id=win, acc=0, count=0. It sets last_grant=win and goes to RUN.
- RUN:
  - req_ready=0 on every channel.
  - Every cycle: if a_sh[0], then acc <= acc + b_sh. Then a_sh <= a_sh>>1, b_sh <= b_sh<<1, count <= count+1.
  - After exactly WIDTH RUN cycles (count==WIDTH-1), the FSM goes to DONE.
  - There is no early termination; zero operands take full latency.
- DONE:
  - res_valid=1, res_data=acc, res_id=id.
  - These outputs stay stable while res_ready=0, for an unbounded time.
  - On res_valid&res_ready, the FSM goes to IDLE and res_valid drops next cycle.
  - res_data/res_id hold their last value afterwards; they are don't-care when res_valid=0.
- Latency: handshake in cycle T gives res_valid high from cycle T+WIDTH+1.
- Throughput: with res_ready=1, one operation per WIDTH+2 cycles. The earliest next grant is the cycle after the result handshake.
- Arithmetic:
  - acc is 2*WIDTH bits and never overflows; the maximum is (2^WIDTH-1)^2, i.e. 65025 for WIDTH=8.
  - After k RUN cycles, acc == b * (a mod 2^k).
- Fairness: a requester holding req_valid high is granted within NUM_REQ grants.
- Requesters must hold req_valid and operands stable until req_ready. The arbiter does not depend on this: operands are sampled only at handshake, and a requester dropping valid before grant is simply skipped.
- Simultaneous events:
  - All requests valid in IDLE: exactly one grant, chosen by rotation.
  - Requests arriving during RUN/DONE wait. They are not queued internally.

Test Plan:
- Single op: reset, req_valid[0]=1, a=13, b=11 -> req_ready[0] high in cycle T; res_valid from T+9; res_data=143, res_id=0.
- Extremes: a=255, b=255 on ch2 -> 65025, res_id=2. a=0, b=200 -> 0 with the same 9-cycle latency. a=1, b=255 -> 255.
- Round-robin: all four valid continuously, res_ready=1 -> grant order 0,1,2,3,0. Each product is correct and tagged with the matching res_id.
- Backpressure: hold res_ready=0 for 20 cycles in DONE -> res_valid, res_data, res_id stable. No req_ready is asserted until the result handshake, and the grant follows the next cycle.
- Reset mid-op: rst_n low 3 cycles into RUN -> next cycle busy=0, res_valid=0. The next request from ch3 with a=7, b=6 yields 42 with id=3, and requester 0 has priority if it is also valid.
- Random: 1000 random operand pairs with random req_valid/res_ready -> each res_data equals a*b of the captured pair. At most one req_ready is high at a time, and none outside IDLE.
